// File: rtl/twiddle_seq_if.sv
// rtl/twiddle_seq_if.sv - control, twiddle stream and status signals of twiddle_seq
interface twiddle_seq_if #(
    parameter int NUM_BU = 8,
    parameter int COEF_W = 12
);
    logic                     start_i;
    logic                     mode_i;
    logic                     ready_i;
    logic [NUM_BU*COEF_W-1:0] zeta_o;
    logic [2:0]               layer_o;
    logic                     valid_o;
    logic                     last_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i, mode_i, ready_i,
        input  zeta_o, layer_o, valid_o, last_o, busy_o, done_o
    );

    modport slave (
        input  start_i, mode_i, ready_i,
        output zeta_o, layer_o, valid_o, last_o, busy_o, done_o
    );
endinterface

// File: rtl/twiddle_seq.sv
// rtl/twiddle_seq.sv - streams per-lane NTT/INTT twiddles for all 7 layers of a 256-point transform
module twiddle_seq #(
    parameter int NUM_BU = 8,
    parameter int COEF_W = 12,
    parameter int Q      = 3329
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    twiddle_seq_if.slave bus
);
    localparam int B  = 128 / NUM_BU;
    localparam int CW = $clog2(B);
    localparam int W  = NUM_BU * COEF_W;

    typedef enum logic {IDLE, RUN} state_t;

    // zeta[k] = 17^brv7(k) mod Q, folded to constants at elaboration
    function automatic int zeta_calc(input int k);
        int     e;
        longint r;
        e = 0;
        r = 1;
        for (int i = 0; i < 7; i++) begin
            e = e | (((k >> i) & 1) << (6 - i));
        end
        for (int i = 0; i < e; i++) begin
            r = (r * 17) % Q;
        end
        return int'(r);
    endfunction

    logic [COEF_W-1:0] zeta_tab [128];

    for (genvar k = 0; k < 128; k++) begin : g_tab
        localparam logic [COEF_W-1:0] ZV = COEF_W'(zeta_calc(k));
        assign zeta_tab[k] = ZV;
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    layer_q, layer_d;
    logic          mode_q, mode_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  zeta_q, zeta_d;

    logic          load;
    logic          accept;
    logic [2:0]    final_layer;
    logic [W-1:0]  lanes;
    logic [6:0]    b_v, g_v, idx_v;
    logic [COEF_W-1:0] z_v;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        layer_d     = layer_q;
        mode_d      = mode_q;
        valid_d     = valid_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;
        accept      = valid_q && bus.ready_i;
        final_layer = mode_q ? 3'd0 : 3'd6;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                    mode_d  = bus.mode_i;
                    layer_d = bus.mode_i ? 3'd6 : 3'd0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    if (cnt_q == CW'(B - 1)) begin
                        if (layer_q == final_layer) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            layer_d = mode_q ? layer_q - 3'd1 : layer_q + 3'd1;
                            load    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        load  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            last_d = (cnt_d == CW'(B - 1));
        end

        // Twiddles for the beat being loaded; the inverse index wraps mod 128 at layer 6 by design
        lanes = '0;
        b_v   = '0;
        g_v   = '0;
        idx_v = '0;
        z_v   = '0;
        for (int l = 0; l < NUM_BU; l++) begin
            b_v   = 7'(l * B) + 7'(cnt_d);
            g_v   = b_v >> (3'd7 - layer_d);
            idx_v = mode_d ? ((7'd2 << layer_d) - 7'd1 - g_v) : ((7'd1 << layer_d) + g_v);
            z_v   = zeta_tab[idx_v];
            if (mode_d && (z_v != '0)) begin
                lanes[l*COEF_W +: COEF_W] = COEF_W'(Q) - z_v;
            end else begin
                lanes[l*COEF_W +: COEF_W] = z_v;
            end
        end

        zeta_d = load ? lanes : zeta_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            layer_q <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zeta_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            layer_q <= layer_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zeta_q  <= zeta_d;
        end
    end

    assign bus.zeta_o  = zeta_q;
    assign bus.layer_o = layer_q;
    assign bus.valid_o = valid_q;
    assign bus.last_o  = last_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
endmodule

// File: doc/twiddle_seq.md
TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk_i is the clock and rst_ni is the reset.
REQ-002 Parameter NUM_BU, default 8, SHALL set the number of butterfly lanes; legal values are 1, 2, 4, 8, 16.
REQ-003 Parameter COEF_W, default 12, SHALL set the width of one twiddle in bits.
REQ-004 Parameter Q, default 3329, SHALL set the modulus.
REQ-005 clk_i  in  1  SHALL be the clock; all flops update on its rising edge.
REQ-006 rst_ni  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 start_i  in  1  SHALL be a one-cycle request to begin a full 7-layer sequence.
REQ-008 mode_i  in  1  SHALL select the transform: 0 = forward NTT, 1 = inverse NTT; it is sampled only with an accepted start_i.
REQ-009 ready_i  in  1  SHALL be the consumer ready signal; a beat is accepted when valid_o && ready_i.
REQ-010 zeta_o  out  NUM_BU*COEF_W  SHALL carry the twiddles, with lane l in bits [l*COEF_W +: COEF_W].
REQ-011 layer_o  out  3  SHALL carry the transform layer of the current beat: 0 = len128 ... 6 = len2.
REQ-012 valid_o  out  1  SHALL indicate that zeta_o, layer_o and last_o are valid.
REQ-013 last_o  out  1  SHALL mark the final beat of the current layer.
REQ-014 busy_o  out  1  SHALL be high from an accepted start until the final beat is accepted.
REQ-015 done_o  out  1  SHALL pulse for one cycle after the final beat of the sequence is accepted.

Function
REQ-016 The internal constant table SHALL be zeta[k] = 17^brv7(k) mod Q for k = 0..127, where brv7 is the 7-bit bit reversal.
REQ-017 The module SHALL use B = 128/NUM_BU beats per layer and 7*B beats per sequence.
REQ-018 Beat c (0..B-1), lane l SHALL cover butterfly index b = l*B + c.
REQ-019 Forward mode SHALL emit layers 0,1,...,6; at layer L the group is g = b >> (7-L) and the lane output is zeta[2^L + g].
REQ-020 Inverse mode SHALL emit layers 6,5,...,0; at layer L the group is g = b >> (7-L) and the lane output is (Q - zeta[2^(L+1) - 1 - g]) mod Q.
REQ-021 The FSM SHALL have two states, IDLE and RUN: IDLE -> RUN on start_i; RUN -> IDLE on acceptance of beat 7*B-1.
REQ-022 All outputs SHALL be registered, and the first beat SHALL present valid_o = 1 in the cycle after start_i is sampled.
REQ-023 Without stalls, the module SHALL emit one beat per cycle, with no bubble between layers.
REQ-024 While valid_o && !ready_i, zeta_o, layer_o, last_o and valid_o SHALL hold stable.
REQ-025 The beat counter SHALL wrap from B-1 to 0 on acceptance; at the wrap, the layer SHALL advance by +1 (forward) or -1 (inverse).
REQ-026 last_o SHALL be high exactly on beat c = B-1 of each layer.
REQ-027 On acceptance of the final beat: valid_o = 0, busy_o = 0 and done_o = 1 in the next cycle; done_o SHALL deassert one cycle later.
REQ-028 start_i while busy_o = 1 SHALL be ignored, and mode_i SHALL NOT be re-sampled.
REQ-029 start_i in the same cycle that done_o = 1 SHALL be accepted, because the FSM is then IDLE.
REQ-030 With NUM_BU = 1, B SHALL be 128; layer_o and the lane mapping SHALL follow REQ-018 to REQ-020 unchanged.
REQ-031 The arithmetic SHALL be exact modulo Q, and every zeta_o lane SHALL lie in the range 0..Q-1.

Reset
REQ-032 Asserting rst_ni low SHALL immediately force state = IDLE, valid_o = 0, busy_o = 0, done_o = 0, last_o = 0, zeta_o = 0, layer_o = 0 and the counters to 0.
REQ-033 Reset mid-sequence SHALL abort the sequence with no done_o pulse; after release, the module SHALL wait in IDLE for a new start_i.

Verification
REQ-034 NUM_BU=8, mode 0, ready_i=1 -> beat 0: all lanes 1729, layer 0; beat 16: lanes 0-3 = 2580 and lanes 4-7 = 3289, layer 1.
REQ-035 NUM_BU=8, mode 0 -> beat 32: lanes 0-1 = 2642, 2-3 = 630, 4-5 = 1897, 6-7 = 848; beat 111: lane 7 = 2154, last_o = 1; done_o pulses at T+113 for start at T.
REQ-036 NUM_BU=8, mode 1 -> beat 0: layer 6, lane 0 = 1175 (Q-2154); final beat: layer 0, all lanes Q-1729 = 1600.
REQ-037 ready_i toggled pseudo-randomly -> beat sequence identical to the unstalled run, and outputs stable throughout every stall.
REQ-038 start_i re-pulsed mid-run, and rst_ni pulsed low at beat 50 -> the re-pulse is ignored; the reset clears all outputs at once with no done_o; a new start afterwards runs a clean sequence.
REQ-039 NUM_BU=16 and NUM_BU=1 -> 56 and 896 beats respectively, with every lane matching the REQ-019 reference model.
